// File: rtl/core_clock_ctrl.sv
// Core clock-enable generator: debounced single-step key, fast/slow free-run pacing and halt handling.
// Produces one-clk core_ce pulses plus a wrapping pulse counter for the debug display.
module core_clock_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FAST_DIV        = 2,
    parameter int unsigned SLOW_DIV        = 4194304,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_key_n,
    input  logic             run_en,
    input  logic             fast_sel,
    input  logic             halt,
    output logic             core_ce,
    output logic [1:0]       mode,
    output logic             key_db,
    output logic [CNT_W-1:0] step_count
);
    localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DIV_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    logic             r_key_meta;
    logic             r_key_sync;
    logic             r_run_meta;
    logic             r_run_sync;
    logic             r_fast_meta;
    logic             r_fast_sync;
    logic             r_fast_prev;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_key_db;
    logic             r_key_db_d;
    logic             r_press;
    state_t           r_state;
    logic             r_core_ce;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_step_count;
    logic [DIV_W-1:0] w_div_last;

    assign w_div_last = r_fast_sync ? FAST_LAST : SLOW_LAST;

    // Two-flop synchronisers for the asynchronous board inputs; keys idle high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_meta  <= 1'b1;
            r_key_sync  <= 1'b1;
            r_run_meta  <= 1'b0;
            r_run_sync  <= 1'b0;
            r_fast_meta <= 1'b0;
            r_fast_sync <= 1'b0;
            r_fast_prev <= 1'b0;
        end else begin
            r_key_meta  <= step_key_n;
            r_key_sync  <= r_key_meta;
            r_run_meta  <= run_en;
            r_run_sync  <= r_run_meta;
            r_fast_meta <= fast_sel;
            r_fast_sync <= r_fast_meta;
            r_fast_prev <= r_fast_sync;
        end
    end

    // Key debounce and one-cycle press detection on the stable level's falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt   <= {DB_W{1'b0}};
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            if (r_key_sync != r_key_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_key_db <= r_key_sync;
                    r_db_cnt <= {DB_W{1'b0}};
                end else begin
                    r_db_cnt <= r_db_cnt + DIV_W'(0) + DB_W'(1);
                end
            end else begin
                r_db_cnt <= {DB_W{1'b0}};
            end
            r_key_db_d <= r_key_db;
            r_press    <= r_key_db_d & ~r_key_db;
        end
    end

    // Pacing FSM; every state change forces core_ce low for that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_MANUAL;
            r_core_ce <= 1'b0;
            r_div     <= {DIV_W{1'b0}};
        end else begin
            case (r_state)
                ST_MANUAL: begin
                    if (r_run_sync && !halt) begin
                        r_state   <= ST_RUN;
                        r_core_ce <= 1'b0;
                        r_div     <= {DIV_W{1'b0}};
                    end else if (r_run_sync && halt) begin
                        r_state   <= ST_HALTED;
                        r_core_ce <= 1'b0;
                    end else begin
                        r_core_ce <= r_press;
                    end
                end
                ST_RUN: begin
                    if (!r_run_sync) begin
                        r_state   <= ST_MANUAL;
                        r_core_ce <= 1'b0;
                    end else if (halt) begin
                        r_state   <= ST_HALTED;
                        r_core_ce <= 1'b0;
                    end else if (r_fast_sync != r_fast_prev) begin
                        // A speed change restarts the period so the new rate starts cleanly
                        r_core_ce <= 1'b0;
                        r_div     <= {DIV_W{1'b0}};
                    end else if (r_div == w_div_last) begin
                        r_core_ce <= 1'b1;
                        r_div     <= {DIV_W{1'b0}};
                    end else begin
                        r_core_ce <= 1'b0;
                        r_div     <= r_div + DIV_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!r_run_sync) begin
                        r_state   <= ST_MANUAL;
                        r_core_ce <= 1'b0;
                    end else if (!halt) begin
                        r_state   <= ST_RUN;
                        r_core_ce <= 1'b0;
                        r_div     <= {DIV_W{1'b0}};
                    end else begin
                        r_core_ce <= r_press;
                    end
                end
                default: begin
                    r_state   <= ST_MANUAL;
                    r_core_ce <= 1'b0;
                    r_div     <= {DIV_W{1'b0}};
                end
            endcase
        end
    end

    // Count issued pulses; wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_count <= {CNT_W{1'b0}};
        end else if (r_core_ce) begin
            r_step_count <= r_step_count + CNT_W'(1);
        end else begin
            r_step_count <= r_step_count;
        end
    end

    assign core_ce    = r_core_ce;
    assign mode       = r_state;
    assign key_db     = r_key_db;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Bench for core_clock_ctrl: cycle-by-cycle reference model plus directed scenarios with literal expectations.
module tb_core_clock_ctrl;
    localparam int DEB  = 4;
    localparam int FDIV = 2;
    localparam int SDIV = 8;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_n = 1'b1, run_en = 1'b0, fast_sel = 1'b0, halt = 1'b0;
    logic core_ce, key_db;
    logic [1:0] mode;
    logic [CW-1:0] step_count;

    logic key2_n = 1'b1, run2 = 1'b0, fast2 = 1'b1, halt2 = 1'b0;
    logic ce2, db2;
    logic [1:0] mode2;
    logic [CW-1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .FAST_DIV(FDIV), .SLOW_DIV(SDIV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .step_key_n(key_n), .run_en(run_en), .fast_sel(fast_sel),
        .halt(halt), .core_ce(core_ce), .mode(mode), .key_db(key_db), .step_count(step_count)
    );

    // Second instance with a divide-by-one fast rate, used for the counter wrap
    core_clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .FAST_DIV(1), .SLOW_DIV(SDIV), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst), .step_key_n(key2_n), .run_en(run2), .fast_sel(fast2),
        .halt(halt2), .core_ce(ce2), .mode(mode2), .key_db(db2), .step_count(cnt2)
    );

    // ---------------- reference model (main instance) ----------------
    logic m_key_h[2];
    logic m_run_h[2];
    logic m_fast_h[2];
    int   m_n, m_fall_n, m_run_len, m_elapsed;
    logic m_db, m_ce, m_fprev;
    logic [1:0] m_mode;
    logic [CW-1:0] m_count;

    task automatic m_reset();
        m_key_h[0] = 1'b1; m_key_h[1] = 1'b1;
        m_run_h[0] = 1'b0; m_run_h[1] = 1'b0;
        m_fast_h[0] = 1'b0; m_fast_h[1] = 1'b0;
        m_n = 0; m_fall_n = -100; m_run_len = 0; m_elapsed = 0;
        m_db = 1'b1; m_ce = 1'b0; m_fprev = 1'b0;
        m_mode = 2'd0; m_count = '0;
    endtask

    task automatic m_step();
        logic ks, rs, fs, press_now, chg, nce;
        int div;
        // values seen by the logic are the inputs from two clocks ago
        ks = m_key_h[1]; rs = m_run_h[1]; fs = m_fast_h[1];
        m_key_h[1] = m_key_h[0];   m_key_h[0] = key_n;
        m_run_h[1] = m_run_h[0];   m_run_h[0] = run_en;
        m_fast_h[1] = m_fast_h[0]; m_fast_h[0] = fast_sel;
        m_n = m_n + 1;
        press_now = (m_n == m_fall_n + 2);
        if (ks != m_db) begin
            m_run_len = m_run_len + 1;
            if (m_run_len == DEB) begin
                m_db = ks;
                m_run_len = 0;
                if (!ks) m_fall_n = m_n;
            end
        end else begin
            m_run_len = 0;
        end
        chg = (fs != m_fprev);
        m_fprev = fs;
        div = fs ? FDIV : SDIV;
        nce = 1'b0;
        case (m_mode)
            2'd0: begin
                if (rs) begin m_mode = halt ? 2'd2 : 2'd1; m_elapsed = 0; end
                else nce = press_now;
            end
            2'd1: begin
                if (!rs) m_mode = 2'd0;
                else if (halt) m_mode = 2'd2;
                else if (chg) m_elapsed = 0;
                else begin
                    m_elapsed = m_elapsed + 1;
                    nce = ((m_elapsed % div) == 0);
                end
            end
            default: begin
                if (!rs) m_mode = 2'd0;
                else if (!halt) begin m_mode = 2'd1; m_elapsed = 0; end
                else nce = press_now;
            end
        endcase
        m_count = m_count + {{(CW-1){1'b0}}, m_ce};
        m_ce = nce;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    // Compare the main instance against the model every cycle
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (core_ce !== m_ce || mode !== m_mode || key_db !== m_db || step_count !== m_count) begin
                bad++;
                $display("FAIL model t=%0t ce=%b want %b mode=%0d want %0d key_db=%b want %b count=%0d want %0d",
                         $time, core_ce, m_ce, mode, m_mode, key_db, m_db, step_count, m_count);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_n = 1'b1; run_en = 1'b0; fast_sel = 1'b0; halt = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [CW-1:0] c0;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick(1);
        chk("rst_ce", core_ce, 0);
        chk("rst_mode", mode, 0);
        chk("rst_keydb", key_db, 1);
        chk("rst_count", step_count, 0);

        // 1: held key gives one pulse 8 clk after the fall
        @(negedge clk); key_n = 1'b0;
        tick(7);  chk("t1_ce_edge7", core_ce, 0);
        tick(1);  chk("t1_ce_edge8", core_ce, 1);
        tick(1);  chk("t1_ce_edge9", core_ce, 0);
        tick(11);
        chk("t1_count", step_count, 1);
        chk("t1_mode", mode, 0);
        chk("t1_keydb", key_db, 0);
        @(negedge clk); key_n = 1'b1;
        tick(10);
        chk("t1_release_keydb", key_db, 1);
        chk("t1_release_count", step_count, 1);

        // 2: 3-clk glitch never reaches key_db
        do_reset();
        @(negedge clk); key_n = 1'b0;
        tick(3);
        @(negedge clk); key_n = 1'b1;
        tick(12);
        chk("t2_keydb", key_db, 1);
        chk("t2_count", step_count, 0);

        // 3: slow run then fast run
        @(negedge clk); run_en = 1'b1; fast_sel = 1'b0;
        tick(40);
        chk("t3_mode", mode, 1);
        chk("t3_slow_count", step_count, 4);
        @(negedge clk); fast_sel = 1'b1;
        tick(10);
        c0 = step_count;
        tick(10);
        chk("t3_fast_rate", 32'(step_count - c0), 5);

        // 4: halt, step past it, resume
        @(negedge clk); halt = 1'b1;
        tick(1);
        chk("t4_mode_halted", mode, 2);
        chk("t4_ce_off", core_ce, 0);
        c0 = step_count;
        @(negedge clk); key_n = 1'b0;
        tick(20);
        @(negedge clk); key_n = 1'b1;
        tick(12);
        chk("t4_one_step", 32'(step_count - c0), 1);
        chk("t4_mode_stays", mode, 2);
        @(negedge clk); halt = 1'b0;
        tick(1);
        chk("t4_mode_run", mode, 1);
        c0 = step_count;
        tick(6);
        chk("t4_resume", 32'(step_count - c0), 2);

        // 6: reset mid-debounce and mid-divide
        @(negedge clk); fast_sel = 1'b0; key_n = 1'b0;
        tick(5);
        rst = 1'b0;
        #1;
        chk("t6_ce", core_ce, 0);
        chk("t6_mode", mode, 0);
        chk("t6_keydb", key_db, 1);
        chk("t6_count", step_count, 0);
        @(negedge clk); key_n = 1'b1; run_en = 1'b0; fast_sel = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick(15);
        chk("t6_idle_count", step_count, 0);
        // reset with a press already registered but its pulse not yet issued
        @(negedge clk); key_n = 1'b0;
        tick(7);
        rst = 1'b0;
        #1;
        chk("t6b_keydb", key_db, 1);
        @(negedge clk); key_n = 1'b1;
        @(negedge clk); rst = 1'b1;
        tick(20);
        chk("t6b_no_pulse", step_count, 0);

        // 5: wrap 0xFFFF -> 0 on the divide-by-one instance
        @(negedge clk); run2 = 1'b1;
        n = 0;
        while (n < 70000) begin
            tick(1);
            n++;
            if (cnt2 == 16'hFFFF) break;
        end
        chk("t5_cycles_to_ffff", n, 65539);
        chk("t5_ce_held", ce2, 1);
        tick(1);
        chk("t5_wrap", cnt2, 0);
        chk("t5_mode", mode2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
